// File: rtl/ahbl_pkg.sv
// Shared definitions for the AHB-Lite master stage: FSM encoding, HTRANS codes
// and address-region geometry.
package ahbl_pkg;

  typedef enum logic [1:0] {
    StNormal = 2'd0,
    StHold   = 2'd1,
    StErr1   = 2'd2,
    StErr2   = 2'd3
  } ahbl_state_e;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam int unsigned RegionW   = 4;
  localparam int unsigned NumSlaves = 4;

endpackage

// File: rtl/ahbl_addr_decode.sv
// Combinational region decode: HADDR[31:28] selects one of the enabled slaves
// for active (NONSEQ/SEQ) transfers only.
module ahbl_addr_decode
  import ahbl_pkg::*;
#(
  parameter logic [NumSlaves-1:0] SLAVE_EN = 4'b1111
) (
  input  logic [RegionW-1:0]   i_region,
  input  logic                 i_active,
  output logic [NumSlaves-1:0] o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_active && (i_region < RegionW'(NumSlaves)) && SLAVE_EN[i_region[1:0]]) begin
      o_sel[i_region[1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/ahbl_master_stage.sv
// AHB-Lite master-side stage: holds address phases a slave is not ready for,
// generates the two-cycle ERROR response for unmapped accesses, muxes data phase.
module ahbl_master_stage
  import ahbl_pkg::*;
#(
  parameter logic [3:0] SLAVE_EN = 4'b1111
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  output logic [31:0] HWDATA_OUT,
  output logic        HREADY_M,
  output logic        HRESP_M,
  output logic [31:0] HRDATA_M,
  output logic [31:0] GATEDHADDR,
  output logic [2:0]  GATEDHSIZE,
  output logic [1:0]  GATEDHTRANS,
  output logic [2:0]  GATEDHBURST,
  output logic        GATEDHWRITE,
  output logic        GATEDHMASTLOCK,
  output logic [3:0]  ADDRSEL,
  output logic [3:0]  DATASEL,
  input  logic [3:0]  SADDRREADY,
  input  logic [3:0]  SDATAREADY,
  input  logic [3:0]  SHRESP,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3
);

  ahbl_state_e r_state, w_state_next;
  logic [3:0]  r_datasel, w_datasel_next;
  logic [31:0] r_haddr;
  logic [2:0]  r_hsize, r_hburst;
  logic [1:0]  r_htrans;
  logic        r_hwrite, r_hmastlock;
  logic        w_capture, w_tgt_ready, w_addr_ok, w_data_ready, w_data_resp, w_unmapped;

  assign HWDATA_OUT = HWDATA;

  always_comb begin
    if (r_state == StHold) begin
      GATEDHADDR     = r_haddr;
      GATEDHSIZE     = r_hsize;
      GATEDHTRANS    = r_htrans;
      GATEDHBURST    = r_hburst;
      GATEDHWRITE    = r_hwrite;
      GATEDHMASTLOCK = r_hmastlock;
    end else begin
      GATEDHADDR     = HADDR;
      GATEDHSIZE     = HSIZE;
      GATEDHTRANS    = HTRANS;
      GATEDHBURST    = HBURST;
      GATEDHWRITE    = HWRITE;
      GATEDHMASTLOCK = HMASTLOCK;
    end
  end

  ahbl_addr_decode #(
    .SLAVE_EN(SLAVE_EN)
  ) u_decode (
    .i_region(GATEDHADDR[31:28]),
    .i_active(GATEDHTRANS[1]),
    .o_sel   (ADDRSEL)
  );

  assign DATASEL      = r_datasel;
  assign w_tgt_ready  = |(ADDRSEL & SADDRREADY);
  assign w_addr_ok    = (ADDRSEL == 4'b0000) || w_tgt_ready;
  assign w_unmapped   = GATEDHTRANS[1] && (ADDRSEL == 4'b0000);
  // With no data phase outstanding the data side is always ready.
  assign w_data_ready = (r_datasel == 4'b0000) || (|(r_datasel & SDATAREADY));
  assign w_data_resp  = |(r_datasel & SHRESP);

  always_comb begin
    HRDATA_M = '0;
    unique case (r_datasel)
      4'b0001: HRDATA_M = HRDATA_S0;
      4'b0010: HRDATA_M = HRDATA_S1;
      4'b0100: HRDATA_M = HRDATA_S2;
      4'b1000: HRDATA_M = HRDATA_S3;
      default: HRDATA_M = '0;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_datasel_next = r_datasel;
    w_capture      = 1'b0;
    HREADY_M       = 1'b1;
    HRESP_M        = 1'b0;
    unique case (r_state)
      StNormal, StErr2: begin
        if (r_state == StErr2) begin
          HRESP_M = 1'b1;
        end else begin
          HREADY_M = w_data_ready && w_addr_ok;
          HRESP_M  = w_data_resp;
        end
        if (w_data_ready) begin
          if (!w_addr_ok) begin
            w_capture      = 1'b1;
            w_state_next   = StHold;
            w_datasel_next = '0;
          end else begin
            w_datasel_next = ADDRSEL;
            w_state_next   = w_unmapped ? StErr1 : StNormal;
          end
        end
      end
      StHold: begin
        HREADY_M = 1'b0;
        if (w_tgt_ready) begin
          w_state_next   = StNormal;
          w_datasel_next = ADDRSEL;
        end
      end
      StErr1: begin
        HREADY_M     = 1'b0;
        HRESP_M      = 1'b1;
        w_state_next = StErr2;
      end
      default: w_state_next = StNormal;
    endcase
    // Master sees an idle, ready bus for the whole reset.
    if (HRESET) begin
      HREADY_M = 1'b1;
      HRESP_M  = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= StNormal;
      r_datasel <= '0;
    end else begin
      r_state   <= w_state_next;
      r_datasel <= w_datasel_next;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_haddr     <= '0;
      r_hsize     <= '0;
      r_htrans    <= '0;
      r_hburst    <= '0;
      r_hwrite    <= 1'b0;
      r_hmastlock <= 1'b0;
    end else if (w_capture) begin
      r_haddr     <= HADDR;
      r_hsize     <= HSIZE;
      r_htrans    <= HTRANS;
      r_hburst    <= HBURST;
      r_hwrite    <= HWRITE;
      r_hmastlock <= HMASTLOCK;
    end
  end

endmodule

// File: tb/tb_ahbl_master_stage.sv
// Scoreboard bench for ahbl_master_stage: expectations are queued per cycle as
// stimulus is driven and compared shortly before the following rising edge.
module tb_ahbl_master_stage;

  localparam logic [31:0] Rd0 = 32'h0000_1111;
  localparam logic [31:0] Rd1 = 32'h1111_2222;
  localparam logic [31:0] Rd2 = 32'h2222_3333;
  localparam logic [31:0] Rd3 = 32'hA5A5_5A5A;
  localparam logic [1:0]  Idle = 2'b00;
  localparam logic [1:0]  Nseq = 2'b10;

  typedef enum int {KReady, KResp, KRdata, KDsel, KAsel, KGaddr, KWdata, KReady2, KResp2,
                    KDsel2} kind_e;
  typedef struct {
    int unsigned cyc;
    kind_e       kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [3:0]  SADDRREADY, SDATAREADY, SHRESP;

  logic [31:0] hwdata_out, hrdata_m, gaddr;
  logic        hready_m, hresp_m;
  logic [2:0]  gsize, gburst;
  logic [1:0]  gtrans;
  logic        gwrite, glock;
  logic [3:0]  addrsel, datasel;

  logic [31:0] hwdata_out2, hrdata_m2, gaddr2;
  logic        hready_m2, hresp_m2;
  logic [2:0]  gsize2, gburst2;
  logic [1:0]  gtrans2;
  logic        gwrite2, glock2;
  logic [3:0]  addrsel2, datasel2;

  exp_t        sb[$];
  int unsigned cyc_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 HCLK = ~HCLK;

  ahbl_master_stage u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HWDATA_OUT(hwdata_out), .HREADY_M(hready_m), .HRESP_M(hresp_m), .HRDATA_M(hrdata_m),
    .GATEDHADDR(gaddr), .GATEDHSIZE(gsize), .GATEDHTRANS(gtrans), .GATEDHBURST(gburst),
    .GATEDHWRITE(gwrite), .GATEDHMASTLOCK(glock), .ADDRSEL(addrsel), .DATASEL(datasel),
    .SADDRREADY(SADDRREADY), .SDATAREADY(SDATAREADY), .SHRESP(SHRESP),
    .HRDATA_S0(Rd0), .HRDATA_S1(Rd1), .HRDATA_S2(Rd2), .HRDATA_S3(Rd3)
  );

  ahbl_master_stage #(
    .SLAVE_EN(4'b1101)
  ) u_dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HWDATA_OUT(hwdata_out2), .HREADY_M(hready_m2), .HRESP_M(hresp_m2),
    .HRDATA_M(hrdata_m2), .GATEDHADDR(gaddr2), .GATEDHSIZE(gsize2), .GATEDHTRANS(gtrans2),
    .GATEDHBURST(gburst2), .GATEDHWRITE(gwrite2), .GATEDHMASTLOCK(glock2),
    .ADDRSEL(addrsel2), .DATASEL(datasel2), .SADDRREADY(SADDRREADY),
    .SDATAREADY(SDATAREADY), .SHRESP(SHRESP),
    .HRDATA_S0(Rd0), .HRDATA_S1(Rd1), .HRDATA_S2(Rd2), .HRDATA_S3(Rd3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, want);
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      KReady:  return {31'b0, hready_m};
      KResp:   return {31'b0, hresp_m};
      KRdata:  return hrdata_m;
      KDsel:   return {28'b0, datasel};
      KAsel:   return {28'b0, addrsel};
      KGaddr:  return gaddr;
      KWdata:  return hwdata_out;
      KReady2: return {31'b0, hready_m2};
      KResp2:  return {31'b0, hresp_m2};
      KDsel2:  return {28'b0, datasel2};
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  task automatic want_at(input int unsigned dly, input kind_e k, input logic [31:0] v,
                         input string tag);
    exp_t e;
    e.cyc  = cyc_cnt + dly;
    e.kind = k;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drv(input logic [31:0] a, input logic [1:0] t, input logic w,
                     input logic [3:0] ar, input logic [3:0] dr, input logic [3:0] rs);
    HADDR      = a;
    HTRANS     = t;
    HWRITE     = w;
    SADDRREADY = ar;
    SDATAREADY = dr;
    SHRESP     = rs;
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  // Monitor: compare every expectation due this cycle just before the rising edge.
  initial begin
    forever begin
      @(negedge HCLK);
      #4;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc_cnt) begin
          check(sb[i].tag, observe(sb[i].kind), sb[i].val);
          sb.delete(i);
        end
      end
      cyc_cnt++;
    end
  end

  initial begin
    HRESET = 1'b1; HSIZE = 3'd2; HBURST = 3'd0; HMASTLOCK = 1'b0; HWDATA = 32'h0;
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt();
    // Reset with a not-ready target on the bus: master must still see ready/OKAY.
    drv(32'h2000_0000, Nseq, 1'b0, 4'b1011, 4'hF, 4'h0);
    want_at(0, KReady, 1, "rst_ready"); want_at(0, KResp, 0, "rst_resp");
    want_at(0, KRdata, 0, "rst_rdata"); want_at(0, KDsel, 0, "rst_dsel");
    nxt();
    HRESET = 1'b0;
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(0, KReady, 1, "idle_ready"); want_at(0, KAsel, 0, "idle_asel");
    nxt();

    // Zero-wait write to slave 1.
    drv(32'h1000_0010, Nseq, 1'b1, 4'hF, 4'hF, 4'h0);
    HWDATA = 32'hDEAD_BEEF;
    want_at(0, KAsel, 4'b0010, "wr_asel"); want_at(0, KReady, 1, "wr_ready_a");
    want_at(0, KGaddr, 32'h1000_0010, "wr_gaddr"); want_at(0, KWdata, 32'hDEAD_BEEF, "wr_wdata");
    want_at(1, KDsel, 4'b0010, "wr_dsel"); want_at(1, KReady, 1, "wr_ready_d");
    want_at(2, KDsel, 0, "wr_dsel_clr");
    nxt();
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt(); nxt();

    // Read slave 2 with address-ready low for three cycles.
    drv(32'h2000_0000, Nseq, 1'b0, 4'b1011, 4'hF, 4'h0);
    want_at(0, KReady, 0, "hold_c0_ready"); want_at(0, KAsel, 4'b0100, "hold_c0_asel");
    nxt();
    drv(32'h3000_0000, Idle, 1'b0, 4'b1011, 4'hF, 4'h0);
    want_at(0, KReady, 0, "hold_c1_ready"); want_at(0, KGaddr, 32'h2000_0000, "hold_c1_gaddr");
    want_at(0, KAsel, 4'b0100, "hold_c1_asel");
    nxt();
    want_at(0, KReady, 0, "hold_c2_ready"); want_at(0, KGaddr, 32'h2000_0000, "hold_c2_gaddr");
    nxt();
    drv(32'h3000_0000, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(0, KReady, 0, "hold_c3_ready"); want_at(0, KGaddr, 32'h2000_0000, "hold_c3_gaddr");
    want_at(1, KDsel, 4'b0100, "hold_dsel"); want_at(1, KReady, 1, "hold_data_ready");
    want_at(1, KRdata, Rd2, "hold_rdata"); want_at(2, KDsel, 0, "hold_dsel_clr");
    nxt(); nxt(); nxt();

    // Unmapped region -> two-cycle ERROR; the ERR2 address phase is accepted.
    drv(32'h5000_0000, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(0, KReady, 1, "err_c0_ready"); want_at(0, KAsel, 0, "err_c0_asel");
    want_at(1, KReady, 0, "err1_ready"); want_at(1, KResp, 1, "err1_resp");
    want_at(1, KDsel, 0, "err1_dsel");
    want_at(2, KReady, 1, "err2_ready"); want_at(2, KResp, 1, "err2_resp");
    want_at(2, KDsel, 0, "err2_dsel");
    want_at(3, KDsel, 4'b0010, "err2_accept_dsel"); want_at(3, KResp, 0, "err_done_resp");
    nxt();
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt();
    drv(32'h1000_0000, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt();
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt(); nxt();

    // Disabled slave 1 on the second instance.
    HRESET = 1'b1;
    nxt();
    HRESET = 1'b0;
    drv(32'h1000_0000, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(0, KReady2, 1, "dis_c0_ready");
    want_at(1, KDsel, 4'b0010, "dis_en_dsel");
    want_at(1, KReady2, 0, "dis_err1_ready"); want_at(1, KResp2, 1, "dis_err1_resp");
    want_at(1, KDsel2, 0, "dis_err1_dsel");
    want_at(2, KReady2, 1, "dis_err2_ready"); want_at(2, KResp2, 1, "dis_err2_resp");
    want_at(3, KResp2, 0, "dis_done_resp");
    nxt();
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt(); nxt(); nxt();

    // Slave 3 read with a two-cycle data stall; next address waits meanwhile.
    drv(32'h3000_0000, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(1, KDsel, 4'b1000, "stall_c1_dsel"); want_at(1, KReady, 0, "stall_c1_ready");
    want_at(2, KDsel, 4'b1000, "stall_c2_dsel"); want_at(2, KReady, 0, "stall_c2_ready");
    want_at(2, KResp, 1, "stall_c2_resp_fwd");
    want_at(3, KReady, 1, "stall_c3_ready"); want_at(3, KRdata, Rd3, "stall_c3_rdata");
    want_at(3, KResp, 0, "stall_c3_resp");
    want_at(4, KDsel, 4'b0001, "stall_next_dsel");
    nxt();
    drv(32'h0000_0004, Nseq, 1'b0, 4'hF, 4'b0111, 4'h0);
    nxt();
    drv(32'h0000_0004, Nseq, 1'b0, 4'hF, 4'b0111, 4'b1000);
    nxt();
    drv(32'h0000_0004, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt();
    // Data phase completes while the next address is refused.
    drv(32'h2000_0000, Nseq, 1'b0, 4'b1011, 4'hF, 4'h0);
    want_at(0, KReady, 0, "cmb_c0_ready"); want_at(0, KRdata, Rd0, "cmb_c0_rdata");
    want_at(1, KDsel, 0, "cmb_c1_dsel"); want_at(1, KReady, 0, "cmb_c1_ready");
    want_at(1, KGaddr, 32'h2000_0000, "cmb_c1_gaddr");
    want_at(2, KDsel, 4'b0100, "cmb_c2_dsel"); want_at(2, KRdata, Rd2, "cmb_c2_rdata");
    want_at(3, KDsel, 0, "cmb_c3_dsel");
    nxt();
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt(); nxt(); nxt();

    // Reset during ERR1.
    drv(32'h5000_0000, Nseq, 1'b0, 4'hF, 4'hF, 4'h0);
    nxt();
    HRESET = 1'b1;
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(0, KReady, 1, "rerr_c1_ready"); want_at(0, KResp, 0, "rerr_c1_resp");
    want_at(1, KReady, 1, "rerr_c2_ready"); want_at(1, KResp, 0, "rerr_c2_resp");
    want_at(1, KDsel, 0, "rerr_c2_dsel");
    nxt();
    HRESET = 1'b0;
    nxt();

    // Reset during HOLD discards the held phase.
    drv(32'h2000_0000, Nseq, 1'b0, 4'b1011, 4'hF, 4'h0);
    want_at(0, KReady, 0, "rhold_c0_ready");
    nxt();
    HRESET = 1'b1;
    drv(32'h0, Idle, 1'b0, 4'hF, 4'hF, 4'h0);
    want_at(1, KReady, 1, "rhold_c2_ready"); want_at(1, KGaddr, 0, "rhold_c2_gaddr");
    want_at(1, KDsel, 0, "rhold_c2_dsel"); want_at(2, KDsel, 0, "rhold_c3_dsel");
    nxt();
    HRESET = 1'b0;
    nxt(); nxt(); nxt();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
